reg_read_unit: RTL and testbench

Read-side controller for the 8-entry register file: the counterpart of the write-enable decoder that drives `to_reg`. It selects one register by 3-bit address, or streams all eight registers starting at an address, onto a registered output with a valid/ready handshake. The ALU/multiplier datapath and the debug dump path use it to fetch operands and register contents.

---
 rtl/reg_read_unit_pkg.sv | 12 +
 rtl/reg_read_unit_mux.sv | 20 ++
 rtl/reg_read_unit.sv | 107 ++++++++++
 tb/tb_reg_read_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/reg_read_unit_pkg.sv
// Shared constants and FSM encodings for the register-file read controller.
package reg_read_unit_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 8;
    localparam int ADDR_W     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SINGLE = 2'b01,
        BURST  = 2'b10
    } state_t;
endpackage

// File: rtl/reg_read_unit_mux.sv
// Combinational 8:1 word selector; read-side partner of the 3-to-8 write decoder.
module _8_to_1_mux #(
    parameter int DATA_WIDTH = reg_read_unit_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = reg_read_unit_pkg::NUM_REGS
) (
    input  logic [NUM_REGS*DATA_WIDTH-1:0]       din,
    input  logic [reg_read_unit_pkg::ADDR_W-1:0] sel,
    output logic [DATA_WIDTH-1:0]                dout
);
    import reg_read_unit_pkg::*;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] words;

    // Slice the flattened bus into indexable words.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
        assign words[g] = din[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign dout = words[sel];
endmodule

// File: rtl/reg_read_unit.sv
// Register-file read controller: single reads or 8-word wrapping bursts
// presented on a registered valid/ready output.
module reg_read_unit #(
    parameter int DATA_WIDTH = reg_read_unit_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = reg_read_unit_pkg::NUM_REGS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]       from_reg,
    input  logic                                 re,
    input  logic [reg_read_unit_pkg::ADDR_W-1:0] Addr,
    input  logic                                 burst,
    input  logic                                 ready,
    output logic [DATA_WIDTH-1:0]                dout,
    output logic [reg_read_unit_pkg::ADDR_W-1:0] dout_addr,
    output logic                                 dout_valid,
    output logic                                 dout_last,
    output logic                                 busy
);
    import reg_read_unit_pkg::*;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   load_addr;
    logic [DATA_WIDTH-1:0] mux_q;
    logic                accept;
    logic                load, load_last, clr, cnt_clr, cnt_inc;

    assign accept = dout_valid & ready;
    assign busy   = (state != IDLE);

    _8_to_1_mux #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_mux (
        .din  (from_reg),
        .sel  (load_addr),
        .dout (mux_q)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and datapath controls; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_last = 1'b0;
        clr       = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        load_addr = dout_addr + 3'd1;
        case (state)
            IDLE: begin
                load_addr = Addr;
                if (re) begin
                    load      = 1'b1;
                    load_last = ~burst;
                    cnt_clr   = 1'b1;
                    state_nxt = burst ? BURST : SINGLE;
                end
            end
            SINGLE: begin
                if (accept) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BURST: begin
                if (accept) begin
                    if (cnt == 3'd7) begin
                        clr       = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        load      = 1'b1;
                        cnt_inc   = 1'b1;
                        load_last = (cnt == 3'd6);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers and word counter; data is snapshotted at load time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            cnt        <= '0;
        end else begin
            if (load) begin
                dout       <= mux_q;
                dout_addr  <= load_addr;
                dout_valid <= 1'b1;
                dout_last  <= load_last;
            end else if (clr) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_reg_read_unit.sv
// Directed bench for reg_read_unit: single read, wrapping burst, stalls,
// ignored request, snapshot behaviour and asynchronous reset.
module tb_reg_read_unit;
    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] from_reg;
    logic [7:0][31:0] regs;
    logic         re, burst, ready;
    logic [2:0]   Addr;
    logic [31:0]  dout;
    logic [2:0]   dout_addr;
    logic         dout_valid, dout_last, busy;

    int total = 0;
    int bad   = 0;

    assign from_reg = regs;

    reg_read_unit dut (
        .clk(clk), .reset(reset), .from_reg(from_reg), .re(re), .Addr(Addr),
        .burst(burst), .ready(ready), .dout(dout), .dout_addr(dout_addr),
        .dout_valid(dout_valid), .dout_last(dout_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input int a, input logic [31:0] d, input bit last);
        check({tag, " valid"}, 32'(dout_valid), 32'd1);
        check({tag, " addr"},  32'(dout_addr),  32'(a));
        check({tag, " data"},  dout,            d);
        check({tag, " last"},  32'(dout_last),  32'(last));
        check({tag, " busy"},  32'(busy),       32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 32'(dout_valid), 32'd0);
        check({tag, " last"},  32'(dout_last),  32'd0);
        check({tag, " busy"},  32'(busy),       32'd0);
    endtask

    task automatic start(input int a, input bit b);
        re = 1'b1; burst = b; Addr = 3'(a);
        step();
        re = 1'b0; burst = 1'b0;
    endtask

    // Run an 8-word burst from 'a'. Optionally stall 'sn' cycles on word index
    // 'si', pulse an ignored re on word 1, and overwrite the stalled register.
    task automatic run_burst(input string tag, input int a, input int si, input int sn,
                             input bit poke, input bit snap);
        int wa;
        logic [31:0] exp_d;
        start(a, 1'b1);
        for (int i = 0; i < 8; i++) begin
            wa = (a + i) % 8;
            exp_d = 32'hA000_0000 + 32'(wa);
            check_word($sformatf("%s w%0d", tag, i), wa, exp_d, i == 7);
            if (i == si) begin
                ready = 1'b0;
                if (snap) regs[wa] = 32'hDEAD_BEEF;
                for (int s = 0; s < sn; s++) begin
                    step();
                    check_word($sformatf("%s stall%0d", tag, s), wa, exp_d, i == 7);
                end
                ready = 1'b1;
            end
            if (poke && i == 1) begin
                re = 1'b1; Addr = 3'd2; burst = 1'b0;
            end
            step();
            re = 1'b0;
        end
        check_idle({tag, " end"});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 32'hA000_0000 + 32'(i);
        reset = 1'b1; re = 1'b0; burst = 1'b0; ready = 1'b1; Addr = 3'd0;
        step(); step();
        check("rst dout", dout, 32'd0);
        check("rst addr", 32'(dout_addr), 32'd0);
        check_idle("rst");
        #3 reset = 1'b0;
        step();

        // Single read with no stall.
        start(5, 1'b0);
        check_word("single", 5, 32'hA000_0005, 1'b1);
        step();
        check_idle("single done");
        check("single dout kept", dout, 32'hA000_0005);

        // Burst with wrap-around.
        run_burst("wrap", 6, -1, 0, 1'b0, 1'b0);
        step();

        // Backpressure on the third word (address 0).
        run_burst("bp", 6, 2, 3, 1'b0, 1'b0);
        step();

        // Ignored request during a burst; nothing follows afterwards.
        run_burst("ign", 6, -1, 0, 1'b1, 1'b0);
        step();
        check_idle("ign after1");
        step();
        check_idle("ign after2");

        // Snapshot: register 3 rewritten while word 3 is stalled.
        run_burst("snap", 0, 3, 2, 1'b0, 1'b1);
        regs[3] = 32'hA000_0003;
        step();

        // Reset after the fourth word is accepted.
        start(0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_word($sformatf("rb w%0d", i), i, 32'hA000_0000 + 32'(i), 1'b0);
            step();
        end
        check_word("rb w4", 4, 32'hA000_0004, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_idle("rb async");
        check("rb dout", dout, 32'd0);
        step();
        #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle($sformatf("rb post%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
